// File: rtl/bounce_generator.sv
// Contact-bounce synthesizer: on trigger, emits an LFSR-timed burst of glitch
// edges on bouncy_out, then settles to the latched target and holds it.
module bounce_generator #(
    parameter int          MAX_BOUNCES   = 8,
    parameter int          GAP_W         = 8,
    parameter int          SETTLE_CYCLES = 2000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trigger,
    input  logic       target,
    input  logic [3:0] n_bounces,
    output logic       bouncy_out,
    output logic       busy,
    output logic       done
);

    localparam int         SET_W   = $clog2(SETTLE_CYCLES + 1);
    localparam logic [3:0] MAX_B   = 4'(MAX_BOUNCES);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

    state_t             state;
    logic [15:0]        lfsr;
    logic [GAP_W-1:0]   gap_cnt;
    logic [4:0]         edges_left;
    logic [SET_W-1:0]   settle_cnt;
    logic               tgt;

    logic [15:0]        lfsr_next;
    logic [GAP_W-1:0]   gap_val;
    logic [3:0]         n_clamped;
    logic [4:0]         edges_req;

    always_comb begin
        lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        gap_val   = (lfsr[GAP_W-1:0] == '0) ? GAP_W'(1) : lfsr[GAP_W-1:0];
        n_clamped = (n_bounces > MAX_B) ? MAX_B : n_bounces;
        edges_req = {n_clamped, 1'b0};
    end

    // Handshake: trigger is sampled only while busy=0 (IDLE, including the done
    // cycle); target and n_bounces are latched on that same edge, and done
    // pulses for one cycle as busy falls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            lfsr       <= LFSR_SEED;
            gap_cnt    <= '0;
            edges_left <= '0;
            settle_cnt <= '0;
            tgt        <= 1'b0;
            bouncy_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        tgt  <= target;
                        busy <= 1'b1;
                        if (edges_req != 5'd0) begin
                            bouncy_out <= ~bouncy_out;
                            edges_left <= edges_req - 5'd1;
                            gap_cnt    <= gap_val;
                            lfsr       <= lfsr_next;
                            state      <= BOUNCE;
                        end else begin
                            bouncy_out <= target;
                            settle_cnt <= SETTLE_LOAD;
                            state      <= SETTLE;
                        end
                    end
                end
                BOUNCE: begin
                    // gap_cnt==1 marks the last cycle of the current gap
                    if (gap_cnt == GAP_W'(1)) begin
                        if (edges_left != 5'd0) begin
                            bouncy_out <= ~bouncy_out;
                            edges_left <= edges_left - 5'd1;
                            gap_cnt    <= gap_val;
                            lfsr       <= lfsr_next;
                        end else begin
                            bouncy_out <= tgt;
                            settle_cnt <= SETTLE_LOAD;
                            state      <= SETTLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SET_W'(1)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
